msb_scan_arb: RTL and testbench
===============================

# msb_scan_arb

Round-robin arbiter and sequencer that shares one 8-bit leading-one detector among `R` requesters, each submitting an `N`-bit operand. The block reports the 1-based position of the highest set bit, or 0 for a zero operand. A granted operand is scanned one byte per clock, from the top byte down. It sits in front of consumers that need MSB positions but cannot each afford an `N`-bit parallel detector.

## Interface
- `N`, 32: operand width; multiple of 8, 8..248.
- `IDW`, 2: requester-ID width; `R = 2**IDW` requesters.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req`  in  R: request per requester; must be held with a stable operand until its `gnt` bit is seen.
- `operand`  in  R*N: requester r's operand at bits `[r*N+N-1 : r*N]`.
- `gnt`  out  R: one-hot, one-cycle pulse; the operand of the granted requester was captured at that edge.
- `busy`  out  1: high whenever FSM is not IDLE.
- `done`  out  1: one-cycle pulse; `result`/`done_id` valid.
- `done_id`  out  IDW: requester the result belongs to.
- `result`  out  8: 1-based MSB position (bit 0 set → 1, bit N-1 → N), 0 if operand is zero; held until next `done`.

## Operation
- **Reset** (`rst_n`=0 at an edge): `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `result`=0. State goes to IDLE. RR pointer `last` is set to R-1, so the first grant goes to 0. Capture register and byte index are cleared. This is honoured in any state, and an in-flight scan is discarded with no `done`.
- **FSM states:** IDLE, SCAN, DONE.
- **IDLE:**
  - If any `req` bit is set, grant the first set bit searching `last+1, last+2, …` modulo R.
  - Capture that operand, pulse `gnt`, and set `last` to the granted ID and `idx` to N/8-1.
  - Then go to SCAN. Otherwise stay in IDLE.
- **SCAN:** the 8-bit detector examines `byte[idx]` and returns p, in 0..8, 1-based, 0 if the byte is zero.
  - If p≠0 and no earlier byte hit: `result` = `idx*8 + p`. The sum is computed at 8-bit width, with no overflow for N≤248.
  - If `idx`==0: the scan ends. If no byte hit, `result` = 0. Go to DONE.
  - Otherwise decrement `idx`. Early termination is governed by the macro below.
- **DONE:** `done`=1 and `done_id` = granted ID for exactly one cycle, then go to IDLE.
- `req` is ignored outside IDLE. A requester that keeps `req` high after `gnt` re-enters arbitration as a new request.
- Simultaneous requests: exactly one grant per IDLE visit. The RR order guarantees each active requester is served within R transactions.

## Timing
- Let E0 be the IDLE edge at which `req` is sampled.
- `gnt` is high in the cycle after E0.
- Scan edges are E1..Ek, where k is the number of bytes examined (1..N/8).
- `done`/`result` are registered and high in the cycle after Ek.
- The state is IDLE after Ek+1, so the next `gnt` is earliest at Ek+2. Back-to-back throughput is one operand per k+2 cycles.
- `busy` is high from the cycle after E0 through the `done` cycle inclusive.

## Configuration
- `MSB_SCAN_EARLY_EXIT_EN` defined:
  - SCAN ends at the first nonzero byte, so k = N/8 − (index of top nonzero byte) for nonzero operands.
  - For a zero operand, k = N/8.
- `MSB_SCAN_EARLY_EXIT_EN` undefined:
  - SCAN always examines all N/8 bytes (k = N/8), giving constant latency.
  - The first (highest) hit is latched; lower bytes never overwrite it.
  - Results are identical in both builds.

## Test plan
- **Reset then idle:** `rst_n`=0 for 2 cycles, no `req` → all outputs 0 and `busy`=0 indefinitely.
- **Single request:** N=32, `req`=4'b0001, op0=0x00008000 → `gnt`=0001 for 1 cycle; `done` with `result`=16, `done_id`=0. `done` comes 3 scan cycles after `gnt` with early exit, 4 without.
- **Edge operands:** op=0x80000000 → 32 (k=1 with early exit); op=0x00000001 → 1; op=0 → `result`=0, k=4 in both builds.
- **Round-robin:** all four `req` held from reset, each dropped after its `gnt` and then reasserted → grant order 0,1,2,3,0. `done_id` matches each grant.
- **Reset mid-operation:** `rst_n`=0 during SCAN → no `done`, `busy`=0 next cycle. The following grant goes to requester 0.

Source files
------------

// File: rtl/msb_scan_arb_if.sv
// msb_scan_arb_if: request/grant and result bus of the shared MSB scanner.
// master = requester side, slave = the arbiter/scanner.
interface msb_scan_arb_if #(
    parameter int N   = 32,
    parameter int IDW = 2
);
    localparam int R = 2 ** IDW;

    logic [R-1:0]   req;
    logic [R*N-1:0] operand;
    logic [R-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [7:0]     result;

    modport master (output req, operand, input gnt, busy, done, done_id, result);
    modport slave  (input req, operand, output gnt, busy, done, done_id, result);
endinterface

// File: rtl/msb_scan_arb.sv
// msb_scan_arb: round-robin arbiter in front of one 8-bit leading-one
// detector. A granted N-bit operand is scanned a byte per clock from the top
// byte down; the 1-based MSB position (0 for zero) is reported with done.
// Optional build macro: MSB_SCAN_EARLY_EXIT_EN -- stop scanning at the first
// nonzero byte instead of always walking all N/8 bytes.
module msb_scan_arb #(
    parameter int N   = 32,
    parameter int IDW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    msb_scan_arb_if.slave bus
);
    localparam int R  = 2 ** IDW;
    localparam int NB = N / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_gid;
    logic [N-1:0]   r_op;
    logic [IW-1:0]  r_idx;
    logic           r_hit;
    logic [7:0]     r_res;
    logic [R-1:0]   r_gnt;
    logic           r_done;
    logic [IDW-1:0] r_done_id;
    logic [7:0]     r_result;

    logic           w_gvld;
    logic [IDW-1:0] w_gid;
    logic [7:0]     w_byte;
    logic [3:0]     w_p;
    logic [7:0]     w_sum;
    logic           w_hit_now;
    logic           w_scan_end;
    logic [7:0]     w_final;

    // Round-robin pick: first requester after last, wrapping modulo R.
    always_comb begin
        w_gvld = 1'b0;
        w_gid  = r_last;
        for (int k = 1; k <= R; k++) begin
            if (!w_gvld && bus.req[IDW'(r_last + IDW'(k))]) begin
                w_gvld = 1'b1;
                w_gid  = IDW'(r_last + IDW'(k));
            end
        end
    end

    // 8-bit leading-one detector on the current byte (0 when byte is zero).
    always_comb begin
        w_byte = r_op[{r_idx, 3'b000} +: 8];
        w_p    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_byte[i]) w_p = 4'(i + 1);
        end
    end

    assign w_sum     = 8'({r_idx, 3'b000}) + {4'd0, w_p};
    assign w_hit_now = (w_p != 4'd0) && !r_hit;
    assign w_final   = w_hit_now ? w_sum : (r_hit ? r_res : 8'd0);

`ifdef MSB_SCAN_EARLY_EXIT_EN
    assign w_scan_end = (r_idx == '0) || (w_p != 4'd0);
`else
    assign w_scan_end = (r_idx == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gvld) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_scan_end) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on grant, walk bytes, latch first hit, publish result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last    <= IDW'(R - 1);
            r_gid     <= '0;
            r_op      <= '0;
            r_idx     <= '0;
            r_hit     <= 1'b0;
            r_res     <= '0;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_result  <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gvld) begin
                        r_gnt  <= R'(1) << w_gid;
                        r_last <= w_gid;
                        r_gid  <= w_gid;
                        r_op   <= bus.operand[w_gid*N +: N];
                        r_idx  <= IW'(NB - 1);
                        r_hit  <= 1'b0;
                        r_res  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_hit_now) begin
                        r_hit <= 1'b1;
                        r_res <= w_sum;
                    end
                    if (w_scan_end) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_gid;
                        r_result  <= w_final;
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.result  = r_result;
endmodule

// File: tb/tb_msb_scan_arb.sv
// tb_msb_scan_arb: directed vectors with hand-computed MSB positions,
// grant order and scan latency for msb_scan_arb (N=32, four requesters).
module tb_msb_scan_arb;
    localparam int N   = 32;
    localparam int IDW = 2;
    localparam int R   = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    msb_scan_arb_if #(.N(N), .IDW(IDW)) bus ();
    msb_scan_arb #(.N(N), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int kk(input int k_early, input int k_full);
`ifdef MSB_SCAN_EARLY_EXIT_EN
        return k_early;
`else
        return k_full;
`endif
    endfunction

    task automatic set_op(input int id, input logic [N-1:0] v);
        bus.operand[id*N +: N] = v;
    endtask

    task automatic wait_gnt(input string tag, input logic [R-1:0] exp_gnt);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.gnt != '0) break;
        end
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
        chk({tag, ".busy_at_gnt"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_id, input int exp_res, input int exp_k);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cnt++;
            if (bus.done) break;
        end
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".lat"}, 32'(cnt), 32'(exp_k));
        chk({tag, ".id"}, 32'(bus.done_id), 32'(exp_id));
        chk({tag, ".res"}, 32'(bus.result), 32'(exp_res));
        tick();
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        chk({tag, ".res_hold"}, 32'(bus.result), 32'(exp_res));
    endtask

    task automatic do_op(input string tag, input int id, input logic [N-1:0] v,
                         input int exp_res, input int exp_k);
        set_op(id, v);
        bus.req[id] = 1'b1;
        wait_gnt(tag, R'(1) << id);
        bus.req[id] = 1'b0;
        wait_done(tag, id, exp_res, exp_k);
    endtask

    int rr_res [R];
    int rr_k   [R];

    initial begin
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.operand = '0;

        // Reset then idle
        tick();
        tick();
        chk("rst.gnt", 32'(bus.gnt), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.done_id", 32'(bus.done_id), 32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle.busy", 32'(bus.busy), 32'd0);
            chk("idle.gnt", 32'(bus.gnt), 32'd0);
            chk("idle.done", 32'(bus.done), 32'd0);
        end

        // Single requests and edge operands
        do_op("op8000",  0, 32'h0000_8000, 16, kk(3, 4));
        do_op("op_top",  1, 32'h8000_0000, 32, kk(1, 4));
        do_op("op_one",  3, 32'h0000_0001, 1,  4);
        do_op("op_zero", 2, 32'h0000_0000, 0,  4);
        do_op("op_ones", 0, 32'hFFFF_FFFF, 32, kk(1, 4));
        do_op("op_two",  1, 32'h0080_0001, 24, kk(2, 4));
        do_op("op_b2",   2, 32'h0001_0000, 17, kk(2, 4));

        // Reset during SCAN discards the scan and resets the RR pointer
        set_op(2, 32'h0000_0001);
        bus.req[2] = 1'b1;
        wait_gnt("mid", 4'b0100);
        bus.req[2] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid.busy", 32'(bus.busy), 32'd0);
        chk("mid.done", 32'(bus.done), 32'd0);
        chk("mid.gnt", 32'(bus.gnt), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("mid.no_done", 32'(bus.done), 32'd0);
        end
        set_op(0, 32'h0000_0040);
        set_op(3, 32'h0000_0100);
        bus.req = 4'b1001;
        wait_gnt("post_rst", 4'b0001);
        bus.req = '0;
        wait_done("post_rst", 0, 7, 4);

        // Round robin with all requests held from reset
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        set_op(0, 32'h0000_0001); rr_res[0] = 1;  rr_k[0] = 4;
        set_op(1, 32'h0000_0100); rr_res[1] = 9;  rr_k[1] = kk(3, 4);
        set_op(2, 32'h0001_0000); rr_res[2] = 17; rr_k[2] = kk(2, 4);
        set_op(3, 32'h0100_0000); rr_res[3] = 25; rr_k[3] = kk(1, 4);
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            int id;
            id = e % R;
            wait_gnt($sformatf("rr%0d", e), R'(1) << id);
            bus.req[id] = 1'b0;
            wait_done($sformatf("rr%0d", e), id, rr_res[id], rr_k[id]);
            bus.req[id] = 1'b1;
        end
        bus.req = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
